// File: rtl/debounce_pkg.sv
// Shared definitions for the shared-timer debounce scheduler.
// State encoding and the default stable-cycle count live here.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_COUNT = 2000000;

endpackage

// File: rtl/debounce_timer.sv
// Up-counter shared by all channels; done flags the last stable cycle.
// Saturates at COUNT-1 so the count can never run past the done value.
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int unsigned COUNT = DEFAULT_COUNT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned TW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [TW-1:0] LAST = TW'(COUNT - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == LAST);

endmodule

// File: rtl/debounce_scheduler.sv
// N-channel debouncer sharing one timer, granted round-robin to channels
// whose synchronized input disagrees with their committed level.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned COUNT = DEFAULT_COUNT,
    localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  noisy_i,
    output logic [N-1:0]  debounced_o,
    output logic [N-1:0]  rise_o,
    output logic [N-1:0]  fall_o,
    output logic          busy_o,
    output logic [AW-1:0] active_ch_o
);

    state_e        state_q, state_d;
    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  debounced_q, debounced_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] activeCh_q, activeCh_d;
    logic          target_q, target_d;
    logic [AW:0]   pick;
    logic [AW-1:0] nextPtr;
    logic          timerClear, timerEn, timerDone;

    // Returns {found, index}; scanning offsets downward lets the smallest
    // cyclic distance from ptr win.
    function automatic logic [AW:0] rrPick(input logic [N-1:0] req,
                                           input logic [AW-1:0] ptr);
        logic [AW:0] res;
        int          idx;
        res = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (req[idx]) res = {1'b1, AW'(idx)};
        end
        return res;
    endfunction

    assign pick    = rrPick(sync2_q ^ debounced_q, ptr_q);
    assign nextPtr = (activeCh_q == AW'(N - 1)) ? '0 : activeCh_q + AW'(1);

    debounce_timer #(.COUNT(COUNT)) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (timerClear),
        .en_i    (timerEn),
        .done_o  (timerDone)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        activeCh_d  = activeCh_q;
        target_d    = target_q;
        debounced_d = debounced_q;
        rise_d      = '0;
        fall_d      = '0;
        timerClear  = 1'b0;
        timerEn     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick[AW]) begin
                    activeCh_d = pick[AW-1:0];
                    target_d   = sync2_q[pick[AW-1:0]];
                    timerClear = 1'b1;
                    state_d    = TIMING;
                end
            end
            TIMING: begin
                // Stability is checked before done so a revert on the last cycle aborts.
                if (sync2_q[activeCh_q] != target_q) begin
                    ptr_d   = nextPtr;
                    state_d = IDLE;
                end else if (timerDone) begin
                    state_d = COMMIT;
                end else begin
                    timerEn = 1'b1;
                end
            end
            COMMIT: begin
                debounced_d[activeCh_q] = target_q;
                rise_d[activeCh_q]      = target_q;
                fall_d[activeCh_q]      = ~target_q;
                ptr_d                   = nextPtr;
                state_d                 = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            debounced_q <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            ptr_q       <= '0;
            activeCh_q  <= '0;
            target_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= noisy_i;
            sync2_q     <= sync1_q;
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            ptr_q       <= ptr_d;
            activeCh_q  <= activeCh_d;
            target_q    <= target_d;
        end
    end

    assign debounced_o = debounced_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign busy_o      = (state_q == TIMING) || (state_q == COMMIT);
    assign active_ch_o = activeCh_q;

endmodule
